// File: rtl/ahb_apb_pkg.sv
// Shared AHB-Lite / APB encodings used by the AHB-to-APB bridge.
package ahb_apb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001,
      HBURST_WRAP4  = 3'b010,
      HBURST_INCR4  = 3'b011,
      HBURST_WRAP8  = 3'b100,
      HBURST_INCR8  = 3'b101,
      HBURST_WRAP16 = 3'b110,
      HBURST_INCR16 = 3'b111
   } hburst_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SETUP  = 2'b01,
      ST_ACCESS = 2'b10
   } apb_state_e;

endpackage

// File: rtl/ahb2apb_bridge_if.sv
// AHB-Lite slave side plus APB master side of one bridge; the bridge uses
// the slave modport, the surrounding system (or bench) uses master.
interface ahb2apb_bridge_if #(
   parameter int ADDR_WIDTH   = 32,
   parameter int HBURST_WIDTH = 3,
   parameter int HPROT_WIDTH  = 4,
   parameter int DATA_WIDTH   = 32
);
   logic [ADDR_WIDTH-1:0]   haddr_i;
   logic [HBURST_WIDTH-1:0] hburst_i;
   logic                    hmastlock_i;
   logic                    hsel_i;
   logic [HPROT_WIDTH-1:0]  hprot_i;
   logic [2:0]              hsize_i;
   logic                    hnonsec_i;
   logic                    hexcl_i;
   logic                    hmaster_i;
   logic [1:0]              htrans_i;
   logic [DATA_WIDTH-1:0]   hwdata_i;
   logic [DATA_WIDTH/8-1:0] hwstrb_i;
   logic                    hwrite_i;
   logic [DATA_WIDTH-1:0]   hrdata_o;
   logic                    hready_o;
   logic                    hreadyout_o;
   logic                    hresp_o;
   logic                    hexokay_o;
   logic [ADDR_WIDTH-1:0]   paddr_o;
   logic                    psel_o;
   logic                    penable_o;
   logic                    pwrite_o;
   logic [DATA_WIDTH-1:0]   pwdata_o;
   logic [DATA_WIDTH/8-1:0] pstrb_o;
   logic [DATA_WIDTH-1:0]   prdata_i;
   logic                    pready_i;

   modport slave (
      input  haddr_i, hburst_i, hmastlock_i, hsel_i, hprot_i, hsize_i,
             hnonsec_i, hexcl_i, hmaster_i, htrans_i, hwdata_i, hwstrb_i,
             hwrite_i, prdata_i, pready_i,
      output hrdata_o, hready_o, hreadyout_o, hresp_o, hexokay_o,
             paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
   );

   modport master (
      output haddr_i, hburst_i, hmastlock_i, hsel_i, hprot_i, hsize_i,
             hnonsec_i, hexcl_i, hmaster_i, htrans_i, hwdata_i, hwstrb_i,
             hwrite_i, prdata_i, pready_i,
      input  hrdata_o, hready_o, hreadyout_o, hresp_o, hexokay_o,
             paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
   );
endinterface

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge: each NONSEQ/SEQ beat becomes one
// APB SETUP+ACCESS transfer, with the AHB data phase stretched until PREADY.
module ahb2apb_bridge
   import ahb_apb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int HBURST_WIDTH = 3,
   parameter int HPROT_WIDTH  = 4,
   parameter int DATA_WIDTH   = 32
) (
   input  logic            hclk_i,
   input  logic            hreset_i,
   ahb2apb_bridge_if.slave bus
);

   apb_state_e            state_q;
   logic [ADDR_WIDTH-1:0] paddr_q;
   logic                  pwrite_q;
   logic                  psel_q;
   logic                  penable_q;
   logic [DATA_WIDTH-1:0] hrdata_q;

   logic hready_d;
   logic accept_d;
   logic rd_done_d;

   always_comb begin
      hready_d = 1'b1;
      case (state_q)
         ST_SETUP:  hready_d = 1'b0;
         ST_ACCESS: hready_d = bus.pready_i;
         default:   hready_d = 1'b1;
      endcase
   end

   assign accept_d  = bus.hsel_i & bus.htrans_i[1] & hready_d;
   assign rd_done_d = (state_q == ST_ACCESS) & bus.pready_i & ~pwrite_q;

   always_ff @(posedge hclk_i) begin
      if (hreset_i) begin
         state_q   <= ST_IDLE;
         paddr_q   <= '0;
         pwrite_q  <= 1'b0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         hrdata_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_d) begin
                  state_q   <= ST_SETUP;
                  paddr_q   <= bus.haddr_i;
                  pwrite_q  <= bus.hwrite_i;
                  psel_q    <= 1'b1;
                  penable_q <= 1'b0;
               end
            end
            ST_SETUP: begin
               state_q   <= ST_ACCESS;
               penable_q <= 1'b1;
            end
            ST_ACCESS: begin
               if (bus.pready_i) begin
                  if (rd_done_d) hrdata_q <= bus.prdata_i;
                  // A beat whose address phase overlaps this completion
                  // goes straight to SETUP so bursts run without gaps.
                  if (accept_d) begin
                     state_q   <= ST_SETUP;
                     paddr_q   <= bus.haddr_i;
                     pwrite_q  <= bus.hwrite_i;
                     psel_q    <= 1'b1;
                     penable_q <= 1'b0;
                  end else begin
                     state_q   <= ST_IDLE;
                     psel_q    <= 1'b0;
                     penable_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               psel_q    <= 1'b0;
               penable_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.paddr_o     = paddr_q;
   assign bus.pwrite_o    = pwrite_q;
   assign bus.psel_o      = psel_q;
   assign bus.penable_o   = penable_q;
   assign bus.pwdata_o    = bus.hwdata_i;
   assign bus.pstrb_o     = pwrite_q ? bus.hwstrb_i : '0;
   assign bus.hreadyout_o = hready_d;
   assign bus.hready_o    = hready_d;
   assign bus.hresp_o     = 1'b0;
   assign bus.hexokay_o   = 1'b0;
   // Completing read data bypasses the capture register for zero latency.
   assign bus.hrdata_o    = rd_done_d ? bus.prdata_i : hrdata_q;

   logic [HBURST_WIDTH-1:0] unused_hburst;
   logic [HPROT_WIDTH-1:0]  unused_hprot;
   logic [7:0]              unused_misc;
   assign unused_hburst = bus.hburst_i;
   assign unused_hprot  = bus.hprot_i;
   assign unused_misc   = {bus.hsize_i, bus.hmastlock_i, bus.hnonsec_i,
                           bus.hexcl_i, bus.hmaster_i, bus.htrans_i[0]};

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed bench for ahb2apb_bridge: inputs change 1 time unit after the
// rising edge, outputs are compared on the falling edge.
module tb_ahb2apb_bridge;
   import ahb_apb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   ahb2apb_bridge_if #(.ADDR_WIDTH(32), .HBURST_WIDTH(3), .HPROT_WIDTH(4), .DATA_WIDTH(32)) bus ();

   ahb2apb_bridge #(.ADDR_WIDTH(32), .HBURST_WIDTH(3), .HPROT_WIDTH(4), .DATA_WIDTH(32)) dut (
      .hclk_i  (clk),
      .hreset_i(rst),
      .bus     (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic to_neg();
      @(negedge clk);
   endtask

   logic [31:0] wrap_tbl [8];

   initial begin
      wrap_tbl[0] = 32'h24; wrap_tbl[1] = 32'h28; wrap_tbl[2] = 32'h2C; wrap_tbl[3] = 32'h30;
      wrap_tbl[4] = 32'h34; wrap_tbl[5] = 32'h38; wrap_tbl[6] = 32'h3C; wrap_tbl[7] = 32'h20;

      bus.haddr_i = '0; bus.hburst_i = HBURST_SINGLE; bus.hmastlock_i = 1'b0;
      bus.hsel_i = 1'b0; bus.hprot_i = '0; bus.hsize_i = 3'b010; bus.hnonsec_i = 1'b0;
      bus.hexcl_i = 1'b0; bus.hmaster_i = 1'b0; bus.htrans_i = HTRANS_IDLE;
      bus.hwdata_i = '0; bus.hwstrb_i = '0; bus.hwrite_i = 1'b0;
      bus.prdata_i = '0; bus.pready_i = 1'b1;

      // Reset state
      step(); step();
      to_neg();
      chk("rst_psel", bus.psel_o, 0);
      chk("rst_penable", bus.penable_o, 0);
      chk("rst_paddr", bus.paddr_o, 0);
      chk("rst_pwrite", bus.pwrite_o, 0);
      chk("rst_hrdata", bus.hrdata_o, 0);
      chk("rst_hready", bus.hready_o, 1);
      chk("rst_hreadyout", bus.hreadyout_o, 1);
      chk("rst_hresp", bus.hresp_o, 0);
      chk("rst_hexokay", bus.hexokay_o, 0);
      step();
      rst = 1'b0;

      // Single write
      bus.hsel_i = 1'b1; bus.htrans_i = HTRANS_NONSEQ; bus.haddr_i = 32'h24; bus.hwrite_i = 1'b1;
      to_neg();
      chk("wr_addr_hready", bus.hready_o, 1);
      chk("wr_addr_psel", bus.psel_o, 0);
      step();
      bus.htrans_i = HTRANS_IDLE; bus.hwdata_i = 32'hDEADBEEF; bus.hwstrb_i = 4'hF;
      to_neg();
      chk("wr_setup_psel", bus.psel_o, 1);
      chk("wr_setup_penable", bus.penable_o, 0);
      chk("wr_setup_paddr", bus.paddr_o, 32'h24);
      chk("wr_setup_pwdata", bus.pwdata_o, 32'hDEADBEEF);
      chk("wr_setup_pstrb", bus.pstrb_o, 4'hF);
      chk("wr_setup_pwrite", bus.pwrite_o, 1);
      chk("wr_setup_hready", bus.hready_o, 0);
      step();
      to_neg();
      chk("wr_access_psel", bus.psel_o, 1);
      chk("wr_access_penable", bus.penable_o, 1);
      chk("wr_access_hready", bus.hready_o, 1);
      step();
      to_neg();
      chk("wr_done_psel", bus.psel_o, 0);
      chk("wr_done_penable", bus.penable_o, 0);

      // Single read
      bus.htrans_i = HTRANS_NONSEQ; bus.haddr_i = 32'h10; bus.hwrite_i = 1'b0;
      step();
      bus.htrans_i = HTRANS_IDLE; bus.prdata_i = 32'h12345678;
      to_neg();
      chk("rd_setup_paddr", bus.paddr_o, 32'h10);
      chk("rd_setup_pwrite", bus.pwrite_o, 0);
      chk("rd_setup_pstrb", bus.pstrb_o, 0);
      step();
      to_neg();
      chk("rd_access_hready", bus.hready_o, 1);
      chk("rd_access_hrdata", bus.hrdata_o, 32'h12345678);
      step();
      bus.prdata_i = 32'hCAFEF00D;
      to_neg();
      chk("rd_hold_hrdata", bus.hrdata_o, 32'h12345678);
      chk("rd_hold_psel", bus.psel_o, 0);

      // Write with two wait states
      bus.htrans_i = HTRANS_NONSEQ; bus.haddr_i = 32'h40; bus.hwrite_i = 1'b1; bus.pready_i = 1'b0;
      step();
      bus.htrans_i = HTRANS_IDLE; bus.haddr_i = 32'h0; bus.hwdata_i = 32'hA5A50001; bus.hwstrb_i = 4'h3;
      for (int c = 0; c < 3; c++) begin
         to_neg();
         chk($sformatf("ws_c%0d_hready", c), bus.hready_o, 0);
         chk($sformatf("ws_c%0d_paddr", c), bus.paddr_o, 32'h40);
         chk($sformatf("ws_c%0d_pwdata", c), bus.pwdata_o, 32'hA5A50001);
         chk($sformatf("ws_c%0d_pwrite", c), bus.pwrite_o, 1);
         chk($sformatf("ws_c%0d_penable", c), bus.penable_o, (c == 0) ? 0 : 1);
         step();
      end
      bus.pready_i = 1'b1;
      to_neg();
      chk("ws_done_hready", bus.hready_o, 1);
      chk("ws_done_pstrb", bus.pstrb_o, 4'h3);
      step();
      to_neg();
      chk("ws_idle_psel", bus.psel_o, 0);

      // WRAP8 read burst, pready always high
      bus.hburst_i = HBURST_WRAP8; bus.hwrite_i = 1'b0; bus.hwstrb_i = 4'h0;
      bus.htrans_i = HTRANS_NONSEQ; bus.haddr_i = wrap_tbl[0];
      step();
      for (int i = 0; i < 8; i++) begin
         if (i < 7) begin
            bus.htrans_i = HTRANS_SEQ; bus.haddr_i = wrap_tbl[i+1];
         end else begin
            bus.htrans_i = HTRANS_IDLE; bus.haddr_i = 32'h0;
         end
         bus.prdata_i = 32'h1000 + i;
         to_neg();
         chk($sformatf("wrap_b%0d_setup", i), {bus.psel_o, bus.penable_o, bus.hready_o}, 3'b100);
         chk($sformatf("wrap_b%0d_paddr_s", i), bus.paddr_o, wrap_tbl[i]);
         step();
         to_neg();
         chk($sformatf("wrap_b%0d_access", i), {bus.psel_o, bus.penable_o, bus.hready_o}, 3'b111);
         chk($sformatf("wrap_b%0d_paddr_a", i), bus.paddr_o, wrap_tbl[i]);
         chk($sformatf("wrap_b%0d_hrdata", i), bus.hrdata_o, 32'h1000 + i);
         chk($sformatf("wrap_b%0d_hresp", i), bus.hresp_o, 0);
         step();
      end
      to_neg();
      chk("wrap_end_psel", bus.psel_o, 0);
      bus.hburst_i = HBURST_SINGLE;

      // No APB activity for IDLE, BUSY or deselected beats
      for (int k = 0; k < 3; k++) begin
         bus.hsel_i   = (k == 2) ? 1'b0 : 1'b1;
         bus.htrans_i = (k == 0) ? HTRANS_IDLE : ((k == 1) ? HTRANS_BUSY : HTRANS_NONSEQ);
         bus.haddr_i  = 32'h60;
         step();
         to_neg();
         chk($sformatf("noact_%0d_psel", k), bus.psel_o, 0);
         chk($sformatf("noact_%0d_hready", k), bus.hready_o, 1);
      end
      step();
      bus.hsel_i = 1'b1; bus.htrans_i = HTRANS_IDLE;

      // Reset while ACCESS is waiting
      bus.htrans_i = HTRANS_NONSEQ; bus.haddr_i = 32'h80; bus.hwrite_i = 1'b0; bus.pready_i = 1'b0;
      step();
      bus.htrans_i = HTRANS_IDLE;
      step();
      to_neg();
      chk("rstmid_pre", {bus.psel_o, bus.penable_o, bus.hready_o}, 3'b110);
      step();
      rst = 1'b1;
      step();
      to_neg();
      chk("rstmid_psel", bus.psel_o, 0);
      chk("rstmid_penable", bus.penable_o, 0);
      chk("rstmid_hready", bus.hready_o, 1);
      chk("rstmid_paddr", bus.paddr_o, 0);
      chk("rstmid_hrdata", bus.hrdata_o, 0);
      rst = 1'b0;
      bus.pready_i = 1'b1;
      step();
      to_neg();
      chk("rstmid_after_psel", bus.psel_o, 0);
      chk("rstmid_after_hready", bus.hready_o, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
